fir_mac_sequencer: RTL and testbench

// - Time-multiplexed FIR controller: one multiply-accumulate unit computes all TAPS terms.
// - Owns a circular delay line of sample registers and walks it against an external coefficient ROM.
// - Accepts one sample per valid/ready transfer; returns one filtered result per valid/ready transfer.
// - Sits between the sample source and the output sink of the FIR filter datapath.

---
 rtl/fir_mac_sequencer.sv | 135 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// ============================================================================
//  Module   : fir_mac_sequencer
//  Brief    : Time-multiplexed FIR controller; one MAC walks a circular delay
//             line against an external coefficient ROM, one tap per cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fir_mac_sequencer #(
  parameter int N     = 16,
  parameter int TAPS  = 8,
  parameter int ACC_W = 2*N + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [N-1:0]     coef_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  localparam int              AW       = $clog2(TAPS);
  localparam logic [AW-1:0]   LAST_IDX = AW'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q,    state_d;
  logic signed [N-1:0]      delay_q [TAPS];
  logic signed [N-1:0]      delay_d [TAPS];
  logic [AW-1:0]            wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0]            k_q,        k_d;
  logic signed [ACC_W-1:0]  acc_q,      acc_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_data_q,  out_data_d;

  logic signed [2*N-1:0]    product;
  logic signed [ACC_W-1:0]  product_ext;

  // rd_ptr tracks (p - k) mod TAPS, so it starts on the freshly written slot
  // and steps backwards with an explicit wrap that works for any TAPS.
  assign product     = coef_data * delay_q[rd_ptr_q];
  assign product_ext = {{(ACC_W-2*N){product[2*N-1]}}, product};

  assign in_ready  = ena && (state_q == S_IDLE);
  assign coef_addr = (state_q == S_MAC) ? k_q : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            delay_d[wr_ptr_q] = in_data;
            rd_ptr_d          = wr_ptr_q;
            wr_ptr_d          = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            acc_d             = '0;
            k_d               = '0;
            state_d           = S_MAC;
          end
        end

        S_MAC: begin
          acc_d    = acc_q + product_ext;
          rd_ptr_d = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end

        S_DONE: begin
          // First DONE cycle publishes the finished sum; afterwards wait for the sink.
          if (!out_valid_q) begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < TAPS; i++) begin
        delay_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
//  Module   : tb_fir_mac_sequencer
//  Brief    : Self-checking bench for fir_mac_sequencer against a convolution
//             model kept over the full accepted-sample history.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fir_mac_sequencer;

  localparam int N     = 16;
  localparam int TAPS  = 8;
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = 2*N + AW;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ena;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     in_data;
  logic [AW-1:0]           coef_addr;
  logic signed [N-1:0]     coef_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;

  logic signed [N-1:0]     coef [TAPS];
  assign coef_data = coef[coef_addr];

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N(N), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int checks   = 0;
  int failures = 0;
  longint hist[$];

  typedef struct {
    logic signed [N-1:0]  x;
    logic signed [63:0]   y;
  } vec_t;
  vec_t imp [TAPS+1];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // y[n] = sum h[k]*x[n-k] over the history since the last reset, wrapped to ACC_W.
  function automatic logic signed [63:0] model_y();
    longint s = 0;
    logic signed [ACC_W-1:0] t;
    for (int k = 0; k < TAPS; k++) begin
      if (k < hist.size())
        s += longint'(coef[k]) * hist[hist.size()-1-k];
    end
    t = s[ACC_W-1:0];
    return t;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    hist.delete();
  endtask

  // One full transaction: optional ena stall at tap stall_k, bp cycles of
  // output backpressure during which a pending input may be presented.
  task automatic send(input logic signed [N-1:0] x, input int stall_k, input int bp,
                      input logic pend, input logic signed [N-1:0] pend_x,
                      output logic signed [63:0] y, output int lat);
    int  guard = 0;
    bit  stalled = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    out_ready = (bp == 0);
    in_valid  = 1'b1;
    in_data   = x;
    step();
    hist.push_back(x);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (stall_k >= 0 && !stalled && coef_addr == AW'(stall_k)) begin
        ena = 1'b0;
        repeat (3) begin
          step();
          lat++;
          check("stall_hold_k", coef_addr, stall_k);
          check("stall_in_ready", in_ready, 0);
        end
        ena = 1'b1;
        stalled = 1;
      end
      step();
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    y = out_data;
    for (int i = 0; i < bp; i++) begin
      in_valid = pend;
      in_data  = pend_x;
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, y);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("handshake_drop", out_valid, 0);
  endtask

  task automatic run_impulse();
    logic signed [63:0] y;
    int lat;
    for (int i = 0; i < TAPS+1; i++) begin
      send(imp[i].x, -1, 0, 1'b0, '0, y, lat);
      check("impulse_y", y, imp[i].y);
      check("impulse_lat", lat, TAPS+1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [63:0] y;
    int lat;
    int guard;

    imp[0].x = 16'sd1;
    imp[0].y = 64'sd1;
    for (int i = 1; i < TAPS+1; i++) begin
      imp[i].x = 16'sd0;
      imp[i].y = (i < TAPS) ? 64'(i + 1) : 64'sd0;
    end

    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < TAPS; k++) coef[k] = 16'(k + 1);

    // Reset state
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef_addr", coef_addr, 0);

    // Impulse response against the table
    run_impulse();

    // Backpressure with a held input sample
    send(16'sd5, -1, 5, 1'b1, 16'sd77, y, lat);
    check("bp_y", y, model_y());
    send(16'sd77, -1, 0, 1'b0, '0, y, lat);
    check("bp_next_y", y, model_y());

    // Signed extreme: h=-1, x=-32768
    do_reset();
    for (int k = 0; k < TAPS; k++) coef[k] = -16'sd1;
    for (int i = 0; i < TAPS; i++) begin
      send(-16'sd32768, -1, 0, 1'b0, '0, y, lat);
      check("ext_y", y, model_y());
    end
    check("ext_final", y, 64'sd262144);

    // ena stall at k=4
    for (int k = 0; k < TAPS; k++) coef[k] = 16'(k + 1);
    for (int i = 0; i < 3; i++) begin
      send(16'($urandom), -1, 0, 1'b0, '0, y, lat);
      check("pre_stall_y", y, model_y());
    end
    send(16'sd1234, 4, 0, 1'b0, '0, y, lat);
    check("stall_y", y, model_y());
    check("stall_lat", lat, TAPS+4);

    // Reset in the middle of MAC after nonzero history
    in_valid = 1'b1;
    in_data  = 16'sd321;
    step();
    in_valid = 1'b0;
    guard = 0;
    while (coef_addr != AW'(3) && guard < 20) begin
      step();
      guard++;
    end
    check("midrst_reach_k3", coef_addr, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hist.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_coef_addr", coef_addr, 0);
    run_impulse();

    // Randomized coefficients, samples and backpressure
    for (int k = 0; k < TAPS; k++) coef[k] = 16'($urandom);
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom), -1, int'($urandom_range(0, 3)), 1'b0, '0, y, lat);
      check("rand_y", y, model_y());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
